// File: rtl/alu_nib_pkg.sv
// Shared types and defaults for the nibble-serial ALU sequencer.
// Optional pipelined turnaround is enabled with ALU_NIB_SEQ_PIPE_EN.
package alu_nib_pkg;

    localparam int NIB_W_DEF  = 4;
    localparam int DATA_W_DEF = 2 * NIB_W_DEF;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_nib_seq_if.sv
// Bundle of upstream, downstream and logic-unit signals of alu_nib_seq.
// The sequencer sits on the slave side; the environment on the master side.
interface alu_nib_seq_if
    import alu_nib_pkg::*;
#(
    parameter int NIB_W  = NIB_W_DEF,
    parameter int DATA_W = 2 * NIB_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    op_e               in_op;

    logic [NIB_W-1:0]  lu_a;
    logic [NIB_W-1:0]  lu_b;
    op_e               lu_op;
    logic [NIB_W-1:0]  lu_res;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_res;
    logic              out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_op,
        input  lu_res, out_ready,
        output in_ready, lu_a, lu_b, lu_op,
        output out_valid, out_res, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_op,
        output lu_res, out_ready,
        input  in_ready, lu_a, lu_b, lu_op,
        input  out_valid, out_res, out_zero
    );

endinterface

// File: rtl/alu_nib_seq_ctrl.sv
// FSM and handshake control for the nibble-serial ALU sequencer.
// ALU_NIB_SEQ_PIPE_EN lets DONE accept the next operation directly.
module alu_nib_seq_ctrl
    import alu_nib_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid_i,
    input  logic   out_ready_i,
    output logic   in_ready_o,
    output logic   out_valid_o,
    output logic   ld_o,
    output logic   cap_lo_o,
    output logic   cap_hi_o,
    output state_e state_o
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        cap_lo_o    = 1'b0;
        cap_hi_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = LO;
            end
            LO: begin
                cap_lo_o = 1'b1;
                state_d  = HI;
            end
            HI: begin
                cap_hi_o = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
`ifdef ALU_NIB_SEQ_PIPE_EN
                // Both handshakes in one cycle chain straight into the next op.
                in_ready_o = out_ready_i;
                if (out_ready_i) state_d = in_valid_i ? LO : IDLE;
`else
                if (out_ready_i) state_d = IDLE;
`endif
            end
        endcase
    end

    assign ld_o    = in_ready_o & in_valid_i;
    assign state_o = state_q;

endmodule

// File: rtl/alu_nib_seq.sv
// Byte ALU built from two passes through an external nibble logic unit.
// Build with ALU_NIB_SEQ_PIPE_EN for 3-cycle instead of 4-cycle throughput.
module alu_nib_seq
    import alu_nib_pkg::*;
#(
    parameter int NIB_W  = NIB_W_DEF,
    parameter int DATA_W = 2 * NIB_W
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_nib_seq_if.slave bus
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    op_e               op_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;

    logic   ld;
    logic   cap_lo;
    logic   cap_hi;
    logic   out_valid;
    logic   in_ready;
    state_e state;

    alu_nib_seq_ctrl u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (bus.in_valid),
        .out_ready_i (bus.out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .ld_o        (ld),
        .cap_lo_o    (cap_lo),
        .cap_hi_o    (cap_hi),
        .state_o     (state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_NOT;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            if (ld) begin
                a_q  <= bus.in_a;
                b_q  <= bus.in_b;
                op_q <= bus.in_op;
            end
            if (cap_lo) res_q[NIB_W-1:0] <= bus.lu_res;
            if (cap_hi) begin
                res_q[DATA_W-1:NIB_W] <= bus.lu_res;
                // Low nibble is already settled, so zero is known on DONE entry.
                zero_q <= (bus.lu_res == '0)
                        && (res_q[NIB_W-1:0] == '0);
            end
        end
    end

    always_comb begin
        bus.lu_a  = '0;
        bus.lu_b  = '0;
        bus.lu_op = OP_NOT;
        unique case (state)
            LO: begin
                bus.lu_a  = a_q[NIB_W-1:0];
                bus.lu_b  = b_q[NIB_W-1:0];
                bus.lu_op = op_q;
            end
            HI: begin
                bus.lu_a  = a_q[DATA_W-1:NIB_W];
                bus.lu_b  = b_q[DATA_W-1:NIB_W];
                bus.lu_op = op_q;
            end
            IDLE, DONE: begin
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_res   = out_valid ? res_q : '0;
    assign bus.out_zero  = out_valid & zero_q;

endmodule

// File: tb/tb_alu_nib_seq.sv
// Directed bench for alu_nib_seq with a behavioural nibble logic unit.
// Honours ALU_NIB_SEQ_PIPE_EN for the expected throughput.
module tb_alu_nib_seq;
    import alu_nib_pkg::*;

`ifdef ALU_NIB_SEQ_PIPE_EN
    localparam int PERIOD = 3;
`else
    localparam int PERIOD = 4;
`endif

    logic clk;
    logic rst_n;
    int   errs;
    int   nchk;
    int   cyc;
    int   acc_cyc;
    int   lat;

    alu_nib_seq_if #(.NIB_W(4), .DATA_W(8)) bus ();

    alu_nib_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        bus.lu_res = '0;
        case (bus.lu_op)
            OP_NOT: bus.lu_res = ~bus.lu_a;
            OP_AND: bus.lu_res = bus.lu_a & bus.lu_b;
            OP_OR:  bus.lu_res = bus.lu_a | bus.lu_b;
            OP_XOR: bus.lu_res = bus.lu_a ^ bus.lu_b;
        endcase
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input op_e op,
                          input logic [7:0] a,
                          input logic [7:0] b);
        for (int i = 0; i < 10 && !bus.in_ready; i++) tick();
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        tick();
        bus.in_valid = 1'b0;
        acc_cyc      = cyc;
    endtask

    task automatic wait_valid(output int l);
        l = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) begin
                l = cyc - acc_cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int v[$];
        bit idle;
        errs = 0;
        nchk = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_NOT;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_res", bus.out_res, 0);
        chk("rst_out_zero", bus.out_zero, 0);
        chk("rst_lu_a", bus.lu_a, 0);
        chk("rst_lu_b", bus.lu_b, 0);
        chk("rst_lu_op", bus.lu_op, 0);

        // NOT A5 with a distinct B to see lu_b forwarded
        accept(OP_NOT, 8'hA5, 8'h6C);
        chk("not_lo_lu_a", bus.lu_a, 4'h5);
        chk("not_lo_lu_b", bus.lu_b, 4'hC);
        chk("not_lo_lu_op", bus.lu_op, 0);
        chk("not_in_ready", bus.in_ready, 0);
        tick();
        chk("not_hi_lu_a", bus.lu_a, 4'hA);
        chk("not_hi_lu_b", bus.lu_b, 4'h6);
        wait_valid(lat);
        chk("not_latency", lat, 2);
        chk("not_res", bus.out_res, 8'h5A);
        chk("not_zero", bus.out_zero, 0);
        chk("not_done_lu_a", bus.lu_a, 0);
        tick();
        chk("not_back_idle", bus.in_ready, 1);
        chk("not_valid_drop", bus.out_valid, 0);

        accept(OP_AND, 8'hF0, 8'h0F);
        wait_valid(lat);
        chk("and_latency", lat, 2);
        chk("and_res", bus.out_res, 8'h00);
        chk("and_zero", bus.out_zero, 1);
        tick();
        chk("and_back_idle", bus.in_ready, 1);

        // XOR held in DONE by backpressure
        bus.out_ready = 1'b0;
        accept(OP_XOR, 8'h3C, 8'hFF);
        wait_valid(lat);
        chk("xor_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            chk("xor_hold_res", bus.out_res, 8'hC3);
            chk("xor_hold_valid", bus.out_valid, 1);
            chk("xor_hold_zero", bus.out_zero, 0);
            chk("xor_hold_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("xor_release_ready", bus.in_ready, 1);
        chk("xor_release_valid", bus.out_valid, 0);

        // back-to-back OR stream
        bus.in_a     = 8'h12;
        bus.in_b     = 8'h40;
        bus.in_op    = OP_OR;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40 && v.size() < 3; c++) begin
            tick();
            if (bus.out_valid) begin
                v.push_back(cyc);
                chk("or_res", bus.out_res, 8'h52);
            end
        end
        bus.in_valid = 1'b0;
        chk("or_count", v.size(), 3);
        if (v.size() == 3) begin
            chk("or_gap1", v[1] - v[0], PERIOD);
            chk("or_gap2", v[2] - v[1], PERIOD);
        end
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            tick();
            idle = bus.in_ready && !bus.out_valid;
        end
        chk("or_drain", idle, 1);

        // asynchronous reset while in HI
        accept(OP_AND, 8'hC7, 8'hB5);
        tick();
        chk("rst_pre_hi_lu_a", bus.lu_a, 4'hC);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        chk("rst_mid_lu_a", bus.lu_a, 0);
        chk("rst_mid_res", bus.out_res, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_result", bus.out_valid, 0);
        end
        chk("rst_after_ready", bus.in_ready, 1);
        accept(OP_XOR, 8'h3C, 8'h0F);
        wait_valid(lat);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_res", bus.out_res, 8'h33);
        chk("post_rst_zero", bus.out_zero, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
